// File: rtl/razor_error_ctrl.sv
// rtl/razor_error_ctrl.sv - Razor timing-error recovery sequencer (stall/restore/flush/replay/fatal)
// Optional error masking via `define RAZOR_ERR_MASK_EN (adds imask port).
module razor_error_ctrl #(
  parameter int ERR_W      = 32,
  parameter int STALL_CYC  = 2,
  parameter int REPLAY_CYC = 3,
  parameter int MAX_RETRY  = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             ireset,
  input  logic [ERR_W-1:0] ierror,
`ifdef RAZOR_ERR_MASK_EN
  input  logic [ERR_W-1:0] imask,
`endif
  output logic             ostall,
  output logic             orestore,
  output logic             oflush,
  output logic             oreplay,
  output logic             ofatal,
  output logic [ERR_W-1:0] oerr_vec,
  output logic [CNT_W-1:0] oerr_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_STALL   = 3'd1;
  localparam logic [2:0] S_RESTORE = 3'd2;
  localparam logic [2:0] S_REPLAY  = 3'd3;
  localparam logic [2:0] S_FATAL   = 3'd4;

  localparam logic [3:0]       STALL_LAST  = 4'(STALL_CYC - 1);
  localparam logic [3:0]       REPLAY_LAST = 4'(REPLAY_CYC - 1);
  localparam logic [2:0]       RETRY_MAX   = 3'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [2:0]       r_state, w_state_nx;
  logic [3:0]       r_tmr, w_tmr_nx;
  logic [2:0]       r_retry, w_retry_nx;
  logic [ERR_W-1:0] r_pend, w_pend_nx;
  logic [ERR_W-1:0] r_vec, w_vec_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [ERR_W-1:0] w_err_eff;
  logic [ERR_W-1:0] w_pend_all;
  logic             r_stall, r_restore, r_flush, r_replay, r_fatal;

`ifdef RAZOR_ERR_MASK_EN
  assign w_err_eff = ierror & ~imask;
`else
  assign w_err_eff = ierror;
`endif

  // Pending view includes an error arriving on the current edge, so a hit on
  // the REPLAY exit edge still chains into another recovery.
  assign w_pend_all = r_pend | w_err_eff;
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_ONE;

  always_comb begin
    w_state_nx = r_state;
    w_tmr_nx   = r_tmr;
    w_retry_nx = r_retry;
    w_pend_nx  = r_pend;
    w_vec_nx   = r_vec;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (|w_err_eff) begin
          w_state_nx = S_STALL;
          w_tmr_nx   = 4'd0;
          w_vec_nx   = w_err_eff;
          w_cnt_nx   = w_cnt_inc;
          w_retry_nx = 3'd1;
        end
      end
      S_STALL: begin
        w_pend_nx = w_pend_all;
        if (r_tmr == STALL_LAST) begin
          w_state_nx = S_RESTORE;
          w_tmr_nx   = 4'd0;
        end else begin
          w_tmr_nx = r_tmr + 4'd1;
        end
      end
      S_RESTORE: begin
        w_pend_nx  = w_pend_all;
        w_state_nx = S_REPLAY;
        w_tmr_nx   = 4'd0;
      end
      S_REPLAY: begin
        if (r_tmr != REPLAY_LAST) begin
          w_pend_nx = w_pend_all;
          w_tmr_nx  = r_tmr + 4'd1;
        end else if (~|w_pend_all) begin
          w_state_nx = S_IDLE;
          w_retry_nx = 3'd0;
          w_pend_nx  = '0;
        end else if (r_retry < RETRY_MAX) begin
          w_state_nx = S_STALL;
          w_tmr_nx   = 4'd0;
          w_retry_nx = r_retry + 3'd1;
          w_cnt_nx   = w_cnt_inc;
          w_vec_nx   = w_pend_all;
          w_pend_nx  = '0;
        end else begin
          w_state_nx = S_FATAL;
          w_pend_nx  = '0;
        end
      end
      S_FATAL: begin
        w_state_nx = S_FATAL;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge ireset) begin
    if (!ireset) begin
      r_state   <= S_IDLE;
      r_tmr     <= 4'd0;
      r_retry   <= 3'd0;
      r_pend    <= '0;
      r_vec     <= '0;
      r_cnt     <= '0;
      r_stall   <= 1'b0;
      r_restore <= 1'b0;
      r_flush   <= 1'b0;
      r_replay  <= 1'b0;
      r_fatal   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_tmr     <= w_tmr_nx;
      r_retry   <= w_retry_nx;
      r_pend    <= w_pend_nx;
      r_vec     <= w_vec_nx;
      r_cnt     <= w_cnt_nx;
      r_stall   <= (w_state_nx == S_STALL) || (w_state_nx == S_RESTORE) ||
                   (w_state_nx == S_FATAL);
      r_restore <= (w_state_nx == S_RESTORE);
      r_flush   <= (w_state_nx == S_RESTORE);
      r_replay  <= (w_state_nx == S_REPLAY);
      r_fatal   <= (w_state_nx == S_FATAL);
    end
  end

  assign ostall     = r_stall;
  assign orestore   = r_restore;
  assign oflush     = r_flush;
  assign oreplay    = r_replay;
  assign ofatal     = r_fatal;
  assign oerr_vec   = r_vec;
  assign oerr_count = r_cnt;

endmodule

// File: tb/tb_razor_error_ctrl.sv
// tb/tb_razor_error_ctrl.sv - scoreboard bench for razor_error_ctrl (honours RAZOR_ERR_MASK_EN)
module tb_razor_error_ctrl;
  localparam int ERR_W      = 32;
  localparam int STALL_CYC  = 2;
  localparam int REPLAY_CYC = 3;
  localparam int MAX_RETRY  = 3;
  localparam int CNT_W      = 4;
  localparam int SEQ_LEN    = STALL_CYC + 1 + REPLAY_CYC;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef RAZOR_ERR_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             ireset;
  logic [ERR_W-1:0] ierror;
`ifdef RAZOR_ERR_MASK_EN
  logic [ERR_W-1:0] imask;
`endif
  logic             ostall, orestore, oflush, oreplay, ofatal;
  logic [ERR_W-1:0] oerr_vec;
  logic [CNT_W-1:0] oerr_count;

  always #5 clk = ~clk;

  razor_error_ctrl #(
    .ERR_W(ERR_W), .STALL_CYC(STALL_CYC), .REPLAY_CYC(REPLAY_CYC),
    .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .ireset(ireset),
    .ierror(ierror),
`ifdef RAZOR_ERR_MASK_EN
    .imask(imask),
`endif
    .ostall(ostall),
    .orestore(orestore),
    .oflush(oflush),
    .oreplay(oreplay),
    .ofatal(ofatal),
    .oerr_vec(oerr_vec),
    .oerr_count(oerr_count)
  );

  typedef struct packed {
    logic             stall;
    logic             restore;
    logic             flush;
    logic             replay;
    logic             fatal;
    logic [ERR_W-1:0] vec;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference: position along one recovery sequence (0 = idle, 1..SEQ_LEN).
  int               m_pos, m_retry, m_count;
  bit               m_fatal;
  logic [ERR_W-1:0] m_pend, m_vec;

  task automatic model_reset();
    m_pos = 0; m_retry = 0; m_count = 0; m_fatal = 1'b0; m_pend = '0; m_vec = '0;
  endtask

  task automatic model_step(input logic [ERR_W-1:0] e);
    logic [ERR_W-1:0] p;
    if (m_fatal) return;
    if (m_pos == 0) begin
      if (e != 0) begin
        m_pos = 1; m_vec = e; m_retry = 1;
        m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
      end
    end else if (m_pos == SEQ_LEN) begin
      p = m_pend | e;
      m_pend = '0;
      if (p == 0) begin
        m_pos = 0; m_retry = 0;
      end else if (m_retry < MAX_RETRY) begin
        m_pos = 1; m_retry++; m_vec = p;
        m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
      end else begin
        m_fatal = 1'b1; m_pos = 0;
      end
    end else begin
      m_pend |= e;
      m_pos++;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.fatal   = m_fatal;
    o.stall   = m_fatal || (m_pos >= 1 && m_pos <= STALL_CYC + 1);
    o.restore = !m_fatal && (m_pos == STALL_CYC + 1);
    o.flush   = o.restore;
    o.replay  = !m_fatal && (m_pos > STALL_CYC + 1);
    o.vec     = m_vec;
    o.cnt     = CNT_W'(m_count);
    return o;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        obs_t e, a;
        e = exp_q.pop_front();
        a = {ostall, orestore, oflush, oreplay, ofatal, oerr_vec, oerr_count};
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL cycle_obs t=%0t act=%h exp=%h", $time, a, e);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h", name, act, exp);
  endtask

  task automatic step(input logic [ERR_W-1:0] e, input logic [ERR_W-1:0] m);
    logic [ERR_W-1:0] eff;
    @(negedge clk);
    ierror = e;
`ifdef RAZOR_ERR_MASK_EN
    imask = m;
`endif
    eff = MASK_EN ? (e & ~m) : e;
    model_step(eff);
    exp_q.push_back(model_obs());
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    drain();
    ireset = 1'b0;
    ierror = '0;
    model_reset();
    #1;
    chk("reset_outputs", {ostall, orestore, oflush, oreplay, ofatal, oerr_vec, oerr_count}, 64'd0);
    @(negedge clk);
    ireset = 1'b1;
  endtask

  initial begin
    logic [ERR_W-1:0] e, m;
    int               r;
    ireset = 1'b0;
    ierror = '0;
`ifdef RAZOR_ERR_MASK_EN
    imask = '0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("por_outputs", {ostall, orestore, oflush, oreplay, ofatal, oerr_vec, oerr_count}, 64'd0);
    @(negedge clk);
    ireset = 1'b1;

    repeat (10) step('0, '0);
    drain();
    chk("idle_count", oerr_count, 0);

    step(32'h0000_0010, '0);
    repeat (SEQ_LEN + 2) step('0, '0);
    drain();
    chk("single_vec", oerr_vec, 32'h10);
    chk("single_count", oerr_count, 1);

    do_reset();
    step(32'h1, '0);
    repeat (3) step('0, '0);
    step(32'h4, '0);
    repeat (2 * SEQ_LEN) step('0, '0);
    drain();
    chk("chain_vec", oerr_vec, 32'h4);
    chk("chain_count", oerr_count, 2);

    do_reset();
    repeat (4 * SEQ_LEN + 4) step(32'h8, '0);
    drain();
    chk("fatal_flag", ofatal, 1);
    chk("fatal_stall", ostall, 1);
    chk("fatal_count", oerr_count, MAX_RETRY);
    ireset = 1'b0;
    model_reset();
    #1;
    chk("fatal_cleared", {ofatal, ostall}, 0);
    @(negedge clk);
    ireset = 1'b1;

    do_reset();
    step(32'h1, '0);
    repeat (STALL_CYC) step('0, '0);
    drain();
    chk("in_restore", {ostall, orestore, oflush}, 3'b111);
    ireset = 1'b0;
    model_reset();
    #1;
    chk("async_drop", {ostall, orestore, oflush}, 0);
    @(negedge clk);
    ireset = 1'b1;
    repeat (4) step('0, '0);
    drain();
    chk("post_reset_count", oerr_count, 0);

    do_reset();
    repeat (CNT_MAX + 3) begin
      step(32'h2, '0);
      repeat (SEQ_LEN) step('0, '0);
    end
    drain();
    chk("count_saturate", oerr_count, CNT_MAX);

`ifdef RAZOR_ERR_MASK_EN
    do_reset();
    step(32'h1, 32'h1);
    repeat (SEQ_LEN) step('0, 32'h1);
    drain();
    chk("mask_no_stall", oerr_count, 0);
    step(32'h3, 32'h1);
    repeat (SEQ_LEN + 1) step('0, 32'h1);
    drain();
    chk("mask_vec", oerr_vec, 32'h2);
    chk("mask_count", oerr_count, 1);
`endif

    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      repeat (150) begin
        r = (ep % 2 == 0) ? $urandom_range(0, 5) : $urandom_range(0, 20);
        if (r == 0) e = $urandom;
        else if (r == 1) e = ERR_W'(1) << $urandom_range(0, ERR_W - 1);
        else e = '0;
        m = MASK_EN ? ($urandom & $urandom) : '0;
        step(e, m);
      end
    end

    drain();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
